// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word-only accesses
// to data_memory. Loads are lane-selected and extended. Sub-word stores use
// read-modify-write. Misaligned, out-of-range and illegal-size requests are
// rejected with a fault response and never touch memory.
module load_store_unit #(
  parameter int MEM_WORD_ADDR_WIDTH = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] resp_read_data,
  output logic [29:0] mem_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_input,
  input  logic [31:0] mem_read_result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte-address bits above the memory's range; any of them set is a fault.
  // The shift overflows to zero for a full 32-bit range, leaving an empty mask.
  localparam logic [31:0] HIGH_MASK = ~((32'h1 << (MEM_WORD_ADDR_WIDTH + 2)) - 32'h1);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_read_data_q, resp_read_data_d;

  logic        req_fault;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [3:0]  lane_hit;
  logic [31:0] merged_word;

  // Request legality check on the incoming (not yet latched) fields.
  always_comb begin
    req_fault = 1'b0;
    if (req_op[1:0] == 2'b11) begin
      req_fault = 1'b1;
    end
    if (req_op[1:0] == SIZE_HALF && req_address[0] != 1'b0) begin
      req_fault = 1'b1;
    end
    if (req_op[1:0] == SIZE_WORD && req_address[1:0] != 2'b00) begin
      req_fault = 1'b1;
    end
    if ((req_address & HIGH_MASK) != 32'h0) begin
      req_fault = 1'b1;
    end
  end

  // Lane select and sign/zero extension of the memory word for loads.
  always_comb begin
    load_byte = 8'h00;
    load_ext  = mem_read_result;
    case (addr_q[1:0])
      2'd0:    load_byte = mem_read_result[7:0];
      2'd1:    load_byte = mem_read_result[15:8];
      2'd2:    load_byte = mem_read_result[23:16];
      default: load_byte = mem_read_result[31:24];
    endcase
    load_half = addr_q[1] ? mem_read_result[31:16] : mem_read_result[15:0];
    case (op_q[1:0])
      SIZE_BYTE: load_ext = op_q[2] ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
      SIZE_HALF: load_ext = op_q[2] ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
      default:   load_ext = mem_read_result;
    endcase
  end

  // Per-byte merge for sub-word stores: replace the addressed lane(s) of the
  // current memory word with the low bits of the store data.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_hit[gi] = (op_q[1:0] == SIZE_BYTE && addr_q[1:0] == LANE) ||
                          (op_q[1:0] == SIZE_HALF && addr_q[1] == LANE[1]);
    assign merged_word[8*gi +: 8] = !lane_hit[gi]            ? mem_read_result[8*gi +: 8] :
                                    (op_q[1:0] == SIZE_HALF) ? wdata_q[8*(gi%2) +: 8] :
                                                               wdata_q[7:0];
  end

  // Next-state, field latching and response generation.
  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    op_d             = op_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    merged_d         = merged_q;
    resp_valid_d     = 1'b0;
    resp_fault_d     = 1'b0;
    resp_read_data_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          op_d    = req_op;
          addr_d  = req_address;
          wdata_d = req_write_data;
          if (req_fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!write_q) begin
          resp_valid_d     = 1'b1;
          resp_read_data_d = load_ext;
          state_d          = IDLE;
        end else if (op_q[1:0] == SIZE_WORD) begin
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          merged_d = merged_word;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-field registers; reset discards any pending operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      write_q          <= 1'b0;
      op_q             <= 3'b0;
      addr_q           <= 32'h0;
      wdata_q          <= 32'h0;
      merged_q         <= 32'h0;
      resp_valid_q     <= 1'b0;
      resp_fault_q     <= 1'b0;
      resp_read_data_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      write_q          <= write_d;
      op_q             <= op_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      merged_q         <= merged_d;
      resp_valid_q     <= resp_valid_d;
      resp_fault_q     <= resp_fault_d;
      resp_read_data_q <= resp_read_data_d;
    end
  end

  // Memory-side outputs come only from registers so the write strobe is
  // stable when data_memory samples it on the negedge.
  always_comb begin
    req_ready        = (state_q == IDLE);
    mem_address      = addr_q[31:2];
    mem_write_enable = 1'b0;
    mem_write_input  = 32'h0;
    if (state_q == ACCESS && write_q && op_q[1:0] == SIZE_WORD) begin
      mem_write_enable = 1'b1;
      mem_write_input  = wdata_q;
    end else if (state_q == WRITE) begin
      mem_write_enable = 1'b1;
      mem_write_input  = merged_q;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_fault     = resp_fault_q;
  assign resp_read_data = resp_read_data_q;

endmodule
